output_collect_memory: RTL
==========================

# output_collect_memory

Parametrised output buffer that collects result words from the multiplier datapath into an on-chip word array and tracks which entries have been filled. It is the successor of the plain write-only output memory and adds a ready/valid write port, an auto-increment address mode, per-word valid tracking, a fill state machine with completion flag, and a registered read-back port. It sits at the end of the datapath and is read by the testbench or host-side readout logic.

## Interface
- NUM_WORDS, 8, number of words stored (≥2, need not be a power of two)
- WORD_BITS, 32, width of each word
- ADDR_BITS, $clog2(NUM_WORDS), address width (localparam, derived)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  sync pulse: clear fill state and begin a new collection
- wr_valid  input  1  write request
- wr_ready  output  1  block accepts a write this cycle
- wr_auto  input  1  1: write to internal pointer; 0: write to wr_addr
- wr_addr  input  ADDR_BITS  explicit write address
- wr_data  input  WORD_BITS  write word
- rd_en  input  1  read request
- rd_addr  input  ADDR_BITS  read address
- rd_data  output  WORD_BITS  read word
- rd_valid  output  1  rd_data valid pulse
- count  output  ADDR_BITS+1  number of distinct entries written
- full  output  1  all NUM_WORDS entries written
- done  output  1  one-cycle pulse on entry to FULL
- addr_err  output  1  one-cycle pulse: write or read address ≥ NUM_WORDS

## Operation
- States: IDLE (after reset), FILL, FULL.
- IDLE: wr_ready=0; start → FILL.
- FILL: wr_ready=1. Accepted write (wr_valid & wr_ready): target = wr_auto ? wr_ptr : wr_addr; mem[target] ← wr_data; valid[target] ← 1; count increments only if valid[target] was 0 (overwrites do not count). wr_ptr increments on every accepted auto write. When count reaches NUM_WORDS → FULL.
- FULL: wr_ready=0, full=1; write requests ignored, no error. start → FILL.
- start in any state: wr_ptr←0, count←0, valid[]←0, state←FILL; a write in the same cycle is dropped (start wins). Memory data is not cleared.
- Write target ≥ NUM_WORDS: no write, no valid/count change, addr_err pulse; wr_ptr still increments in auto mode (cannot exceed NUM_WORDS−1 before FULL unless explicit writes collided).
- Read: rd_en samples rd_addr; next cycle rd_valid=1 and rd_data = valid[rd_addr] ? mem[rd_addr] : 0. rd_addr ≥ NUM_WORDS → rd_data=0, rd_valid=1, addr_err pulse. Reads allowed in every state.
- Width rules: count is ADDR_BITS+1 bits so NUM_WORDS is representable; no other arithmetic.

## Timing
- Reset values: wr_ready=0, rd_data=0, rd_valid=0, count=0, full=0, done=0, addr_err=0, state IDLE, wr_ptr=0, valid[]=0. Memory array not reset.
- Write latency: data stored at the accepting edge; count/full updated the same edge (visible next cycle).
- wr_ready drops in the cycle after the final distinct write; done asserted in that same cycle, for one cycle.
- Read latency: one cycle, registered; rd_valid is a pulse per rd_en.
- Reset asserted mid-fill: immediate return to IDLE, all flags cleared; in-flight read discarded.

## Configuration
- OUT_MEM_BYPASS_EN defined: read and accepted write to the same address in the same cycle return the new wr_data (with valid treated as 1).
- Not defined: same-cycle read returns the pre-write contents (0 if the entry was not yet valid).

## Test plan
- Reset, start, 8 auto writes 0x11…0x88 with wr_valid held → count 1..8, done pulse one cycle after 8th write, full=1, wr_ready=0; reads 0..7 return 0x11..0x88 each one cycle later.
- Explicit writes to addr 3 twice (0xA, 0xB) → count=1, read addr 3 = 0xB; read addr 4 = 0.
- NUM_WORDS=6, explicit write to addr 7 → addr_err pulse, count unchanged; read addr 6 → rd_data=0, addr_err pulse.
- start asserted with wr_valid on 4th write → write dropped, count=0, all reads return 0, subsequent auto write lands at addr 0.
- Same-cycle write 0x5A and read at addr 2 (previously 0x33): with OUT_MEM_BYPASS_EN → 0x5A; without → 0x33.
- rst_n low for one cycle after 5 writes → outputs at reset values, wr_ready=0 until start.

Source files
------------

// File: rtl/output_collect_memory_if.sv
// Write/read/status bundle for output_collect_memory.
// The master side drives requests; the slave side is the memory.
interface output_collect_memory_if #(
    parameter int NUM_WORDS = 8,
    parameter int WORD_BITS = 32
);
    localparam int ADDR_BITS = $clog2(NUM_WORDS);

    logic                 start;
    logic                 wr_valid;
    logic                 wr_ready;
    logic                 wr_auto;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [WORD_BITS-1:0] wr_data;
    logic                 rd_en;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [WORD_BITS-1:0] rd_data;
    logic                 rd_valid;
    logic [ADDR_BITS:0]   count;
    logic                 full;
    logic                 done;
    logic                 addr_err;

    modport master (
        output start, wr_valid, wr_auto, wr_addr, wr_data, rd_en, rd_addr,
        input  wr_ready, rd_data, rd_valid, count, full, done, addr_err
    );

    modport slave (
        input  start, wr_valid, wr_auto, wr_addr, wr_data, rd_en, rd_addr,
        output wr_ready, rd_data, rd_valid, count, full, done, addr_err
    );
endinterface

// File: rtl/output_collect_memory.sv
// Collecting output buffer: ready/valid writes with per-word valid tracking,
// fill FSM with done pulse, registered read-back. OUT_MEM_BYPASS_EN enables write-to-read forwarding.
module output_collect_memory #(
    parameter int NUM_WORDS = 8,
    parameter int WORD_BITS = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output_collect_memory_if.slave  bus
);
    localparam int ADDR_BITS = $clog2(NUM_WORDS);
    localparam logic [ADDR_BITS:0] NW = (ADDR_BITS+1)'(NUM_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    logic [1:0]           state;
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS:0]   count;
    logic [NUM_WORDS-1:0] valid;
    logic [WORD_BITS-1:0] mem [NUM_WORDS];

    logic                 wr_fire;
    logic [ADDR_BITS-1:0] wr_tgt;
    logic                 wr_oob;
    logic                 wr_ok;
    logic                 wr_new;
    logic [ADDR_BITS:0]   count_inc;
    logic                 rd_oob;
    logic [WORD_BITS-1:0] rd_word;

    // start wins over a same-cycle write
    assign wr_fire   = bus.wr_valid & bus.wr_ready & ~bus.start;
    assign wr_tgt    = bus.wr_auto ? wr_ptr : bus.wr_addr;
    assign wr_oob    = {1'b0, wr_tgt} >= NW;
    assign wr_ok     = wr_fire & ~wr_oob;
    assign wr_new    = wr_ok & ~valid[wr_tgt];
    assign count_inc = count + 1'b1;
    assign rd_oob    = {1'b0, bus.rd_addr} >= NW;

    always_comb begin
        rd_word = '0;
        if (!rd_oob && valid[bus.rd_addr])
            rd_word = mem[bus.rd_addr];
`ifdef OUT_MEM_BYPASS_EN
        if (wr_ok && wr_tgt == bus.rd_addr)
            rd_word = bus.wr_data;
`endif
    end

    assign bus.wr_ready = (state == S_FILL);
    assign bus.full     = (state == S_FULL);
    assign bus.count    = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            count        <= '0;
            valid        <= '0;
            bus.done     <= 1'b0;
            bus.addr_err <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            bus.done     <= 1'b0;
            bus.addr_err <= (wr_fire & wr_oob) | (bus.rd_en & rd_oob);
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en)
                bus.rd_data <= rd_word;

            if (bus.start) begin
                state  <= S_FILL;
                wr_ptr <= '0;
                count  <= '0;
                valid  <= '0;
            end else if (wr_fire) begin
                // pointer advances even when the target is out of range
                if (bus.wr_auto)
                    wr_ptr <= wr_ptr + 1'b1;
                if (wr_new) begin
                    valid[wr_tgt] <= 1'b1;
                    count         <= count_inc;
                    if (count_inc == NW) begin
                        state    <= S_FULL;
                        bus.done <= 1'b1;
                    end
                end
            end
        end
    end

    // data array is deliberately not reset; valid[] masks stale words
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_tgt] <= bus.wr_data;
    end
endmodule
